// File: rtl/shreg8_sequencer.sv
// Command sequencer driving an 8-bit universal shift register (load/rotate/fill).
// Define SHSEQ_CAPTURE_EN to add cap_out, which collects every bit shifted out of Q.
module shreg8_sequencer #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clc,
    input  logic             R,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic [W-1:0]     din,
    input  logic             fill_bit,
    input  logic [W-1:0]     Q,
    output logic [1:0]       mode,
    output logic             sIn,
    output logic             busy,
    output logic             done
`ifdef SHSEQ_CAPTURE_EN
    ,
    output logic [W-1:0]     cap_out
`endif
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROTR = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_FILL = 2'b11;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_RIGHT = 2'b01;
    localparam logic [1:0] M_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     ldata_r;
    logic             fill_r;
    logic [CNT_W-1:0] cnt_ld;
    logic             accept;

    // LOAD always shifts a full register width regardless of cnt_in
    assign cnt_ld = (op == OP_LOAD) ? CNT_W'(W) : cnt_in;
    assign accept = (state == IDLE) && start;

    always_ff @(posedge clc or negedge R) begin
        if (!R) begin
            state   <= IDLE;
            op_r    <= '0;
            cnt_r   <= '0;
            ldata_r <= '0;
            fill_r  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_r    <= op;
                cnt_r   <= cnt_ld;
                ldata_r <= din;
                fill_r  <= fill_bit;
            end else if (state == RUN) begin
                cnt_r <= cnt_r - CNT_W'(1);
                if (op_r == OP_LOAD) begin
                    ldata_r <= {ldata_r[W-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        mode     = M_HOLD;
        sIn      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (cnt_ld == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                unique case (op_r)
                    OP_LOAD: begin
                        mode = M_LEFT;
                        sIn  = ldata_r[W-1];
                    end
                    OP_ROTR: begin
                        mode = M_RIGHT;
                        sIn  = Q[0];
                    end
                    OP_ROTL: begin
                        mode = M_LEFT;
                        sIn  = Q[W-1];
                    end
                    OP_FILL: begin
                        mode = M_RIGHT;
                        sIn  = fill_r;
                    end
                    default: ;
                endcase
                if (cnt_r == CNT_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef SHSEQ_CAPTURE_EN
    always_ff @(posedge clc or negedge R) begin
        if (!R) begin
            cap_out <= '0;
        end else if (accept) begin
            cap_out <= '0;
        end else if (state == RUN) begin
            if (mode == M_RIGHT) begin
                cap_out <= {Q[0], cap_out[W-1:1]};
            end else if (mode == M_LEFT) begin
                cap_out <= {cap_out[W-2:0], Q[W-1]};
            end
        end
    end
`endif

endmodule

// File: tb/tb_shreg8_sequencer.sv
// Scoreboard bench for shreg8_sequencer with a behavioural shift register on Q.
// Expected results come from plain rotate/fill arithmetic on the modelled register.
module tb_shreg8_sequencer;

    logic       clc = 1'b0;
    logic       R = 1'b0;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [3:0] cnt_in = 4'd0;
    logic [7:0] din = 8'd0;
    logic       fill_bit = 1'b0;
    logic [7:0] q;
    logic [1:0] mode;
    logic       sIn;
    logic       busy;
    logic       done;
`ifdef SHSEQ_CAPTURE_EN
    logic [7:0] cap_out;
`endif

    shreg8_sequencer #(.W(8), .CNT_W(4)) dut (
        .clc(clc),
        .R(R),
        .start(start),
        .op(op),
        .cnt_in(cnt_in),
        .din(din),
        .fill_bit(fill_bit),
        .Q(q),
        .mode(mode),
        .sIn(sIn),
        .busy(busy),
        .done(done)
`ifdef SHSEQ_CAPTURE_EN
        ,
        .cap_out(cap_out)
`endif
    );

    always #5 clc = ~clc;

    int cyc = 0;
    always @(posedge clc) cyc <= cyc + 1;

    // the shift register being controlled
    always @(posedge clc or negedge R) begin
        if (!R) q <= 8'h00;
        else begin
            case (mode)
                2'b01: q <= {sIn, q[7:1]};
                2'b10: q <= {q[6:0], sIn};
                default: q <= q;
            endcase
        end
    end

    typedef struct {
        logic [7:0] q;
        int         lat;
        int         start_cyc;
        logic       chk_sin;
        logic [7:0] sin_seq;
        logic [7:0] cap;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] cur_q = 8'h00;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_q(input logic [1:0] o, input int n,
                                           input logic [7:0] d, input logic fb,
                                           input logic [7:0] q0);
        logic [15:0] dbl;
        int k;
        k = n % 8;
        dbl = {q0, q0};
        case (o)
            2'b00: return d;
            2'b01: begin dbl = dbl >> k; return dbl[7:0]; end
            2'b10: begin dbl = dbl << k; return dbl[15:8]; end
            default: begin
                if (n >= 8) return {8{fb}};
                dbl = {{8{fb}}, q0} >> n;
                return dbl[7:0];
            end
        endcase
    endfunction

    function automatic logic [7:0] model_cap(input logic [1:0] o, input int n,
                                             input logic fb, input logic [7:0] q0);
        logic [7:0] c;
        logic b;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            case (o)
                2'b00: b = q0[7-k];
                2'b01: b = q0[k%8];
                2'b10: b = q0[7-(k%8)];
                default: b = (k < 8) ? q0[k] : fb;
            endcase
            if (o == 2'b01 || o == 2'b11) c = {b, c[7:1]};
            else c = {c[6:0], b};
        end
        return c;
    endfunction

    // monitor: per-cycle legality plus scoreboard pop on every done pulse
    initial begin
        int shifts;
        logic [7:0] sin_acc;
        exp_t e;
        shifts = 0;
        sin_acc = 8'h00;
        forever begin
            @(negedge clc);
            if (!R) begin
                shifts = 0;
                sin_acc = 8'h00;
            end else begin
                if (mode == 2'b11) check("mode_11", int'(mode), 0);
                if (!busy) check("idle_mode", int'(mode), 0);
                if (mode != 2'b00) begin
                    shifts++;
                    sin_acc = {sin_acc[6:0], sIn};
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected done=0 (t=%0t)", $time);
                    end else begin
                        e = sb.pop_front();
                        check("q_at_done", int'(q), int'(e.q));
                        check("latency", cyc - e.start_cyc, e.lat);
                        check("shift_cycles", shifts, e.lat);
                        if (e.chk_sin) check("load_sin_seq", int'(sin_acc), int'(e.sin_seq));
`ifdef SHSEQ_CAPTURE_EN
                        check("cap_out", int'(cap_out), int'(e.cap));
`endif
                    end
                    shifts = 0;
                    sin_acc = 8'h00;
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clc);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    // called at a negedge; returns at the following negedge
    task automatic issue(input logic [1:0] o, input logic [3:0] n,
                         input logic [7:0] d, input logic fb, input bit push);
        exp_t e;
        int eff;
        wait_idle();
        start = 1'b1;
        op = o;
        cnt_in = n;
        din = d;
        fill_bit = fb;
        if (push) begin
            eff = (o == 2'b00) ? 8 : int'(n);
            e.q = model_q(o, eff, d, fb, cur_q);
            e.lat = eff;
            e.start_cyc = cyc + 1;
            e.chk_sin = (o == 2'b00);
            e.sin_seq = d;
            e.cap = model_cap(o, eff, fb, cur_q);
            sb.push_back(e);
            cur_q = e.q;
        end
        @(negedge clc);
        start = 1'b0;
        op = 2'($urandom);
        cnt_in = 4'($urandom);
        din = 8'($urandom);
        fill_bit = 1'($urandom);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clc);
        check("rst_mode", int'(mode), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(q), 0);
        #2 R = 1'b1;
        @(negedge clc);

        issue(2'b00, 4'd0, 8'hA5, 1'b0, 1);
        issue(2'b01, 4'd3, 8'h00, 1'b0, 1);
        issue(2'b00, 4'd5, 8'hA5, 1'b0, 1);
        issue(2'b10, 4'd1, 8'h00, 1'b0, 1);
        issue(2'b00, 4'd0, 8'h00, 1'b0, 1);
        issue(2'b11, 4'd4, 8'h00, 1'b1, 1);
        issue(2'b01, 4'd0, 8'h00, 1'b0, 1);

        // start pulses during RUN and DONE must be ignored
        issue(2'b00, 4'd0, 8'h3C, 1'b0, 1);
        @(negedge clc);
        start = 1'b1;
        op = 2'b01;
        cnt_in = 4'd5;
        @(negedge clc);
        start = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clc);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
        start = 1'b1;
        op = 2'b11;
        cnt_in = 4'd3;
        fill_bit = 1'b1;
        @(negedge clc);
        start = 1'b0;

        // reset in the middle of a LOAD
        issue(2'b00, 4'd0, 8'h5A, 1'b0, 0);
        @(negedge clc);
        @(posedge clc);
        #2 R = 1'b0;
        #1;
        check("rst_mid_mode", int'(mode), 0);
        check("rst_mid_busy", int'(busy), 0);
        cur_q = 8'h00;
        @(negedge clc);
        #2 R = 1'b1;
        @(negedge clc);
        issue(2'b00, 4'd0, 8'hC3, 1'b0, 1);

        issue(2'b00, 4'd0, 8'hA5, 1'b0, 1);
        issue(2'b01, 4'd8, 8'h00, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 1);
        end

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clc);
            n++;
        end
        check("sb_drain", sb.size(), 0);
        repeat (3) @(negedge clc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
